// File: rtl/crank_wheel_gen.sv
// Crank/cam trigger-wheel emulator: N-M VR tooth train plus once-per-cycle cam pulse.
// Optional build macro CRANK_GEN_RAMP_EN: per-tooth prescaler ramp instead of per-tooth reload.
module crank_wheel_gen #(
  parameter int unsigned TEETH_TOTAL     = 60,
  parameter int unsigned TEETH_MISSING   = 2,
  parameter int unsigned TICKS_PER_TOOTH = 64,
  parameter int unsigned CAM_ON_TOOTH    = 4,
  parameter int unsigned CAM_OFF_TOOTH   = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic [3:0] ramp_step,
  input  logic       ramp_dir,
  output logic       vr,
  output logic       cam,
  output logic [5:0] tooth_idx,
  output logic       gap,
  output logic       rev_strobe
);

  localparam int unsigned LAST_TOOTH = TEETH_TOTAL - TEETH_MISSING - 1;
  localparam int unsigned GAP_TOP    = (TEETH_MISSING + 1) * TICKS_PER_TOOTH - 1;
  localparam int unsigned TCKC_W     = (GAP_TOP < 2) ? 1 : $clog2(GAP_TOP + 1);

  localparam logic [TCKC_W-1:0] NORM_TOP    = TCKC_W'(TICKS_PER_TOOTH - 1);
  localparam logic [TCKC_W-1:0] LONG_TOP    = TCKC_W'(GAP_TOP);
  localparam logic [5:0]        LAST_IDX    = 6'(LAST_TOOTH);
  localparam logic [5:0]        CAM_ON_IDX  = 6'(CAM_ON_TOOTH);
  localparam logic [5:0]        CAM_OFF_IDX = 6'(CAM_OFF_TOOTH);

  logic              run_q, run_d;
  logic [7:0]        scnt_q, scnt_d;
  logic [TCKC_W-1:0] tckc_q, tckc_d;
  logic [7:0]        presc_cur_q, presc_cur_d;
  logic              cam_phase_q, cam_phase_d;
  logic              vr_q, vr_d;
  logic              cam_q, cam_d;
  logic [5:0]        tooth_q, tooth_d;
  logic              gap_q, gap_d;
  logic              rev_q, rev_d;

  logic              tick;
  logic [TCKC_W-1:0] top;
  logic [7:0]        presc_next;

`ifdef CRANK_GEN_RAMP_EN
  logic [8:0] ramp_sum;

  // Saturating ramp so a long sweep parks at the speed limit instead of wrapping.
  always_comb begin
    ramp_sum = {1'b0, presc_cur_q} + {5'b0, ramp_step};
    if (ramp_dir) begin
      presc_next = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];
    end else begin
      presc_next = (presc_cur_q < {4'b0, ramp_step}) ? 8'h00 : presc_cur_q - {4'b0, ramp_step};
    end
  end
`else
  logic unused_ramp;
  assign unused_ramp = ^{ramp_step, ramp_dir};
  assign presc_next  = presc;
`endif

  assign tick = (scnt_q == presc_cur_q);
  assign top  = (tooth_q == LAST_IDX) ? LONG_TOP : NORM_TOP;

  always_comb begin
    run_d       = run_q;
    scnt_d      = scnt_q;
    tckc_d      = tckc_q;
    presc_cur_d = presc_cur_q;
    cam_phase_d = cam_phase_q;
    vr_d        = vr_q;
    cam_d       = cam_q;
    tooth_d     = tooth_q;
    gap_d       = gap_q;
    rev_d       = 1'b0;

    if (!en) begin
      run_d       = 1'b0;
      scnt_d      = '0;
      tckc_d      = '0;
      presc_cur_d = '0;
      cam_phase_d = 1'b0;
      vr_d        = 1'b0;
      cam_d       = 1'b0;
      tooth_d     = '0;
      gap_d       = 1'b0;
    end else if (!run_q) begin
      // Start-up cycle: latch the speed and begin at tooth 0 without a rev strobe.
      run_d       = 1'b1;
      presc_cur_d = presc;
      scnt_d      = '0;
      tckc_d      = '0;
      tooth_d     = '0;
    end else begin
      scnt_d = tick ? 8'h00 : scnt_q + 8'h01;
      if (tick) begin
        if (tckc_q == top) begin
          tckc_d = '0;
          vr_d   = 1'b0;
          if (tooth_q == LAST_IDX) begin
            tooth_d     = '0;
            cam_phase_d = ~cam_phase_q;
            rev_d       = 1'b1;
          end else begin
            tooth_d = tooth_q + 6'd1;
          end
          if (tooth_d == CAM_ON_IDX && cam_phase_d) begin
            cam_d = 1'b1;
          end
          if (tooth_d == CAM_OFF_IDX) begin
            cam_d = 1'b0;
          end
          gap_d       = (tooth_d == LAST_IDX);
          presc_cur_d = presc_next;
        end else begin
          if (tckc_q == (top >> 1)) begin
            vr_d = 1'b1;
          end
          tckc_d = tckc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      scnt_q      <= '0;
      tckc_q      <= '0;
      presc_cur_q <= '0;
      cam_phase_q <= 1'b0;
      vr_q        <= 1'b0;
      cam_q       <= 1'b0;
      tooth_q     <= '0;
      gap_q       <= 1'b0;
      rev_q       <= 1'b0;
    end else begin
      run_q       <= run_d;
      scnt_q      <= scnt_d;
      tckc_q      <= tckc_d;
      presc_cur_q <= presc_cur_d;
      cam_phase_q <= cam_phase_d;
      vr_q        <= vr_d;
      cam_q       <= cam_d;
      tooth_q     <= tooth_d;
      gap_q       <= gap_d;
      rev_q       <= rev_d;
    end
  end

  assign vr         = vr_q;
  assign cam        = cam_q;
  assign tooth_idx  = tooth_q;
  assign gap        = gap_q;
  assign rev_strobe = rev_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen: tooth timing, gap, cam phasing, prescaler, enable and reset.
module tb_crank_wheel_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] presc;
  logic [3:0] ramp_step;
  logic       ramp_dir;
  logic       vr;
  logic       cam;
  logic [5:0] tooth_idx;
  logic       gap;
  logic       rev_strobe;

  int assertCount = 0;
  int failCount   = 0;

  crank_wheel_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .presc     (presc),
    .ramp_step (ramp_step),
    .ramp_dir  (ramp_dir),
    .vr        (vr),
    .cam       (cam),
    .tooth_idx (tooth_idx),
    .gap       (gap),
    .rev_strobe(rev_strobe)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic e, input logic [7:0] p, input logic [3:0] s, input logic d);
    en        = e;
    presc     = p;
    ramp_step = s;
    ramp_dir  = d;
  endtask

  task automatic stepClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);

    // Reset state
    stepClocks(3);
    checkOutput("rst_vr", 32'(vr), 32'd0);
    checkOutput("rst_cam", 32'(cam), 32'd0);
    checkOutput("rst_tooth", 32'(tooth_idx), 32'd0);
    checkOutput("rst_gap", 32'(gap), 32'd0);
    checkOutput("rst_rev", 32'(rev_strobe), 32'd0);
    rst = 1'b1;
    stepClocks(2);
    checkOutput("idle_vr", 32'(vr), 32'd0);

    // Period and duty at presc 0, full first revolution
    applyStimulus(1'b1, 8'd0, 4'd0, 1'b0);
    stepClocks(1);
    checkOutput("start_tooth", 32'(tooth_idx), 32'd0);
    checkOutput("start_rev", 32'(rev_strobe), 32'd0);
    stepClocks(31);
    checkOutput("vr_low_31", 32'(vr), 32'd0);
    stepClocks(1);
    checkOutput("vr_high_32", 32'(vr), 32'd1);
    stepClocks(31);
    checkOutput("vr_high_63", 32'(vr), 32'd1);
    stepClocks(1);
    checkOutput("vr_fall_64", 32'(vr), 32'd0);
    checkOutput("tooth1", 32'(tooth_idx), 32'd1);
    checkOutput("no_rev_t1", 32'(rev_strobe), 32'd0);
    stepClocks(192);
    checkOutput("tooth4_rev1", 32'(tooth_idx), 32'd4);
    checkOutput("cam_off_rev1", 32'(cam), 32'd0);
    stepClocks(3392);
    checkOutput("gap_tooth", 32'(tooth_idx), 32'd57);
    checkOutput("gap_high", 32'(gap), 32'd1);
    checkOutput("gap_vr_low", 32'(vr), 32'd0);
    stepClocks(95);
    checkOutput("gap_vr_low95", 32'(vr), 32'd0);
    stepClocks(1);
    checkOutput("gap_vr_high96", 32'(vr), 32'd1);
    stepClocks(95);
    checkOutput("gap_end_gap", 32'(gap), 32'd1);
    checkOutput("gap_end_rev", 32'(rev_strobe), 32'd0);
    stepClocks(1);
    checkOutput("wrap_vr", 32'(vr), 32'd0);
    checkOutput("wrap_tooth", 32'(tooth_idx), 32'd0);
    checkOutput("wrap_rev", 32'(rev_strobe), 32'd1);
    checkOutput("wrap_gap", 32'(gap), 32'd0);
    stepClocks(1);
    checkOutput("rev_pulse_end", 32'(rev_strobe), 32'd0);

    // Cam on the second revolution, off on the third, on again on the fourth
    stepClocks(254);
    checkOutput("cam_pre_on", 32'(cam), 32'd0);
    stepClocks(1);
    checkOutput("cam_on", 32'(cam), 32'd1);
    checkOutput("cam_on_tooth", 32'(tooth_idx), 32'd4);
    stepClocks(3199);
    checkOutput("cam_pre_off", 32'(cam), 32'd1);
    stepClocks(1);
    checkOutput("cam_off", 32'(cam), 32'd0);
    checkOutput("cam_off_tooth", 32'(tooth_idx), 32'd54);
    stepClocks(640);
    checkOutput("cam_rev3_tooth", 32'(tooth_idx), 32'd4);
    checkOutput("cam_rev3_off", 32'(cam), 32'd0);
    stepClocks(3840);
    checkOutput("cam_rev4_on", 32'(cam), 32'd1);

`ifndef CRANK_GEN_RAMP_EN
    // presc 0 -> 1 mid-tooth: current tooth keeps its pace, the next one doubles
    stepClocks(10);
    applyStimulus(1'b1, 8'd1, 4'd0, 1'b0);
    stepClocks(53);
    checkOutput("pc_tooth4_end", 32'(tooth_idx), 32'd4);
    stepClocks(1);
    checkOutput("pc_tooth5", 32'(tooth_idx), 32'd5);
    stepClocks(63);
    checkOutput("pc_vr_low63", 32'(vr), 32'd0);
    stepClocks(1);
    checkOutput("pc_vr_high64", 32'(vr), 32'd1);
    stepClocks(63);
    checkOutput("pc_tooth5_end", 32'(tooth_idx), 32'd5);
    stepClocks(1);
    checkOutput("pc_tooth6", 32'(tooth_idx), 32'd6);
    checkOutput("pc_vr_fall", 32'(vr), 32'd0);
`else
    // Ramp 250 -> 253 -> 255 -> 255 seen through tooth durations of 251/254/256 clocks per tick
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);
    stepClocks(1);
    checkOutput("rp_idle", 32'(tooth_idx), 32'd0);
    applyStimulus(1'b1, 8'd250, 4'd3, 1'b1);
    stepClocks(1);
    stepClocks(16063);
    checkOutput("rp_t0_end", 32'(tooth_idx), 32'd0);
    stepClocks(1);
    checkOutput("rp_t1", 32'(tooth_idx), 32'd1);
    stepClocks(16255);
    checkOutput("rp_t1_end", 32'(tooth_idx), 32'd1);
    stepClocks(1);
    checkOutput("rp_t2", 32'(tooth_idx), 32'd2);
    stepClocks(16383);
    checkOutput("rp_t2_end", 32'(tooth_idx), 32'd2);
    stepClocks(1);
    checkOutput("rp_t3", 32'(tooth_idx), 32'd3);
`endif

    // Drop en mid-gap, then restart from tooth 0 without a rev strobe
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);
    stepClocks(1);
    checkOutput("en_off_tooth", 32'(tooth_idx), 32'd0);
    checkOutput("en_off_cam", 32'(cam), 32'd0);
    applyStimulus(1'b1, 8'd0, 4'd0, 1'b0);
    stepClocks(1);
    stepClocks(3748);
    checkOutput("mid_gap", 32'(gap), 32'd1);
    checkOutput("mid_gap_tooth", 32'(tooth_idx), 32'd57);
    checkOutput("mid_gap_vr", 32'(vr), 32'd1);
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);
    stepClocks(1);
    checkOutput("drop_gap", 32'(gap), 32'd0);
    checkOutput("drop_vr", 32'(vr), 32'd0);
    checkOutput("drop_tooth", 32'(tooth_idx), 32'd0);
    applyStimulus(1'b1, 8'd0, 4'd0, 1'b0);
    stepClocks(1);
    checkOutput("restart_tooth", 32'(tooth_idx), 32'd0);
    checkOutput("restart_rev", 32'(rev_strobe), 32'd0);
    stepClocks(32);
    checkOutput("restart_vr", 32'(vr), 32'd1);
    stepClocks(32);
    checkOutput("restart_t1", 32'(tooth_idx), 32'd1);
    checkOutput("restart_t1_rev", 32'(rev_strobe), 32'd0);

    // Asynchronous reset mid-tooth clears outputs before any clock edge
    stepClocks(40);
    checkOutput("pre_arst_vr", 32'(vr), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_vr", 32'(vr), 32'd0);
    checkOutput("arst_tooth", 32'(tooth_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stepClocks(1);
    stepClocks(32);
    checkOutput("post_arst_vr", 32'(vr), 32'd1);
    checkOutput("post_arst_tooth", 32'(tooth_idx), 32'd0);
    stepClocks(32);
    checkOutput("post_arst_t1", 32'(tooth_idx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
